// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges execute and load results onto one register-file write port.
// Load data wins conflicts unless the execute path has waited STARVE_MAX cycles.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    input  logic [4:0]        p0_rd,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_ready,
    input  logic              p1_valid,
    input  logic [4:0]        p1_rd,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_ready,
    output logic              rf_wr_en,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_wd,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [PERF_W-1:0] perf_conflicts
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    function automatic logic [3:0] starve_inc(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    logic [3:0]        r_starve_cnt;
    logic [PERF_W-1:0] r_perf;
    logic              r_vld_p1;
    logic [4:0]        r_rd_p1;
    logic [DATA_W-1:0] r_wd_p1;

    logic              w_gnt0_p0;
    logic              w_gnt1_p0;
    logic              w_xfer_p0;
    logic [4:0]        w_rd_p0;
    logic [DATA_W-1:0] w_wd_p0;

    // Stage p0: grant decision and winner select
    assign w_gnt0_p0 = p0_valid & (~p1_valid | (r_starve_cnt == STARVE_LIM));
    assign w_gnt1_p0 = p1_valid & ~w_gnt0_p0;
    assign p0_ready  = w_gnt0_p0 & rst_n;
    assign p1_ready  = w_gnt1_p0 & rst_n;
    assign w_xfer_p0 = p0_ready | p1_ready;
    assign w_rd_p0   = w_gnt0_p0 ? p0_rd   : p1_rd;
    assign w_wd_p0   = w_gnt0_p0 ? p0_data : p1_data;

    // Stage p1: registered write, x0 writes complete the handshake but never enable the port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_rd_p1  <= '0;
            r_wd_p1  <= '0;
        end else if (w_xfer_p0) begin
            r_vld_p1 <= (w_rd_p0 != 5'd0);
            r_rd_p1  <= w_rd_p0;
            r_wd_p1  <= w_wd_p0;
        end else begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!p0_valid || w_gnt0_p0) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= starve_inc(r_starve_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (p0_valid && p1_valid) begin
            r_perf <= perf_inc(r_perf);
        end
    end

    assign rf_wr_en       = r_vld_p1;
    assign rf_rd          = r_rd_p1;
    assign rf_wd          = r_wd_p1;
    assign fwd_valid      = r_vld_p1;
    assign fwd_rd         = r_rd_p1;
    assign fwd_data       = r_wd_p1;
    assign perf_conflicts = r_perf;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_wb_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int PERF_W     = 4;
    localparam int PERF_MAX   = (1 << PERF_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              p0_valid;
    logic [4:0]        p0_rd;
    logic [DATA_W-1:0] p0_data;
    logic              p0_ready;
    logic              p1_valid;
    logic [4:0]        p1_rd;
    logic [DATA_W-1:0] p1_data;
    logic              p1_ready;
    logic              rf_wr_en;
    logic [4:0]        rf_rd;
    logic [DATA_W-1:0] rf_wd;
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [DATA_W-1:0] fwd_data;
    logic [PERF_W-1:0] perf_conflicts;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // behavioural model state
    int          m_waited = 0;
    int          m_perf   = 0;
    bit          m_wr     = 0;
    int          m_rd     = 0;
    logic [31:0] m_wd     = '0;

    wb_port_arbiter #(
        .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_rd(p0_rd), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data), .p1_ready(p1_ready),
        .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .perf_conflicts(perf_conflicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -1 none, 0 execute port, 1 load port
    function automatic int winner(input bit v0, input bit v1, input int waited);
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (!v0 && v1) return 1;
        return (waited >= STARVE_MAX) ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = winner(p0_valid, p1_valid, m_waited);
        if (!rst_n) begin
            m_wr = 0; m_rd = 0; m_wd = '0; m_waited = 0; m_perf = 0;
        end else begin
            if (w == 0) begin
                m_wr = (p0_rd != 0); m_rd = int'(p0_rd); m_wd = p0_data;
            end else if (w == 1) begin
                m_wr = (p1_rd != 0); m_rd = int'(p1_rd); m_wd = p1_data;
            end else begin
                m_wr = 0;
            end
            if (p0_valid && p1_valid) m_perf = (m_perf < PERF_MAX) ? m_perf + 1 : m_perf;
            if (p0_valid && w != 0) m_waited = (m_waited < STARVE_MAX) ? m_waited + 1 : m_waited;
            else m_waited = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int w;
            w = winner(p0_valid, p1_valid, m_waited);
            chk("m_p0_ready", 32'(p0_ready), 32'(rst_n && w == 0));
            chk("m_p1_ready", 32'(p1_ready), 32'(rst_n && w == 1));
            chk("m_rf_wr_en", 32'(rf_wr_en), 32'(m_wr));
            chk("m_rf_rd",    32'(rf_rd),    32'(m_rd));
            chk("m_rf_wd",    rf_wd,         m_wd);
            chk("m_fwd_valid", 32'(fwd_valid), 32'(m_wr));
            chk("m_fwd_rd",   32'(fwd_rd),   32'(m_rd));
            chk("m_fwd_data", fwd_data,      m_wd);
            chk("m_perf",     32'(perf_conflicts), 32'(m_perf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int perf_before;
        bit a0, a1;
        rst_n = 1'b0;
        p0_valid = 1'b1; p0_rd = 5'd1; p0_data = 32'h11;
        p1_valid = 1'b1; p1_rd = 5'd2; p1_data = 32'h22;

        // reset with both ports requesting
        step();
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_p0_ready", 32'(p0_ready), 0);
            chk("rst_p1_ready", 32'(p1_ready), 0);
            chk("rst_wr_en", 32'(rf_wr_en), 0);
            chk("rst_rd", 32'(rf_rd), 0);
            chk("rst_wd", rf_wd, 0);
            chk("rst_perf", 32'(perf_conflicts), 0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_p1_first", 32'(p1_ready), 1);
        chk("rel_p0_wait", 32'(p0_ready), 0);
        step();
        chk("rel_wr_en", 32'(rf_wr_en), 1);
        chk("rel_rd", 32'(rf_rd), 2);
        chk("rel_wd", rf_wd, 32'h22);
        chk("rel_perf", 32'(perf_conflicts), 1);
        p1_valid = 1'b0;
        #1;
        chk("rel_p0_next", 32'(p0_ready), 1);
        step();
        chk("rel_p0_rd", 32'(rf_rd), 1);
        chk("rel_p0_wd", rf_wd, 32'h11);
        p0_valid = 1'b0;

        // single execute write
        p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'h1234_5678;
        #1;
        chk("single_ready", 32'(p0_ready), 1);
        step();
        p0_valid = 1'b0;
        chk("single_wr_en", 32'(rf_wr_en), 1);
        chk("single_rd", 32'(rf_rd), 5);
        chk("single_wd", rf_wd, 32'h1234_5678);
        chk("single_fwd", fwd_data, 32'h1234_5678);
        step();
        chk("single_idle_wr_en", 32'(rf_wr_en), 0);
        chk("single_hold_rd", 32'(rf_rd), 5);

        // load to x0
        p1_valid = 1'b1; p1_rd = 5'd0; p1_data = 32'hFFFF_FFFF;
        #1;
        chk("x0_ready", 32'(p1_ready), 1);
        step();
        p1_valid = 1'b0;
        chk("x0_wr_en", 32'(rf_wr_en), 0);
        chk("x0_rd", 32'(rf_rd), 0);
        chk("x0_wd", rf_wd, 32'hFFFF_FFFF);

        // same destination on both ports
        perf_before = int'(perf_conflicts);
        p0_valid = 1'b1; p0_rd = 5'd3; p0_data = 32'hA;
        p1_valid = 1'b1; p1_rd = 5'd3; p1_data = 32'hB;
        #1;
        chk("conf_p1_wins", 32'(p1_ready), 1);
        step();
        p1_valid = 1'b0;
        chk("conf_first_rd", 32'(rf_rd), 3);
        chk("conf_first_wd", rf_wd, 32'hB);
        step();
        p0_valid = 1'b0;
        chk("conf_second_wr", 32'(rf_wr_en), 1);
        chk("conf_second_wd", rf_wd, 32'hA);
        chk("conf_perf", 32'(perf_conflicts), 32'(perf_before + 1));

        // execute starvation under continuous loads
        p0_valid = 1'b1; p0_rd = 5'd8; p0_data = 32'h80;
        p1_valid = 1'b1; p1_rd = 5'd7; p1_data = 32'h0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("starve_p0_ready", 32'(p0_ready), 32'(c == 4));
            chk("starve_p1_ready", 32'(p1_ready), 32'(c != 4));
            step();
            if (c == 4) p0_valid = 1'b0;
            else p1_data = p1_data + 32'd1;
        end
        p1_valid = 1'b0;

        // reset while a write sits in the output register
        p0_valid = 1'b1; p0_rd = 5'd9; p0_data = 32'h99;
        step();
        p0_valid = 1'b0;
        p1_valid = 1'b1; p1_rd = 5'd10; p1_data = 32'hAA;
        rst_n = 1'b0;
        #1;
        chk("mid_wr_pending", 32'(rf_wr_en), 1);
        chk("mid_p1_blocked", 32'(p1_ready), 0);
        step();
        chk("mid_cancel", 32'(rf_wr_en), 0);
        chk("mid_rd_clr", 32'(rf_rd), 0);
        rst_n = 1'b1;
        #1;
        chk("mid_retry_ready", 32'(p1_ready), 1);
        step();
        p1_valid = 1'b0;
        chk("mid_retry_rd", 32'(rf_rd), 10);
        chk("mid_retry_wd", rf_wd, 32'hAA);

        // conflict counter saturation
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("sat_start", 32'(perf_conflicts), 0);
        p0_valid = 1'b1; p0_rd = 5'd4; p0_data = 32'h4;
        p1_valid = 1'b1; p1_rd = 5'd6; p1_data = 32'h6;
        for (int n = 1; n <= 20; n++) begin
            step();
            chk("sat_perf", 32'(perf_conflicts), 32'((n < 15) ? n : 15));
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a0 = p0_valid & p0_ready;
            a1 = p1_valid & p1_ready;
            @(posedge clk);
            #1;
            if (!p0_valid || a0) begin
                p0_valid = ($urandom_range(0, 99) < 60);
                p0_rd    = 5'($urandom_range(0, 7));
                p0_data  = $urandom;
            end
            if (!p1_valid || a1) begin
                p1_valid = ($urandom_range(0, 99) < 70);
                p1_rd    = 5'($urandom_range(0, 7));
                p1_data  = $urandom;
            end
            rst_n = ($urandom_range(0, 199) != 0);
        end
        rst_n = 1'b1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
